// File: rtl/cla32_seq_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : CLA_16bit_withLCU, cla32_seq_adder                        |
// | Description : 32-bit add/subtract built around a single 16-bit         |
// |               carry-lookahead adder that is used twice per operation:  |
// |               low half first, then high half using the stored carry.   |
// | Ports (cla32_seq_adder):                                               |
// |   clk       in   1  clock, rising edge                                 |
// |   rst       in   1  asynchronous reset, active low                     |
// |   start     in   1  request pulse, accepted only when idle             |
// |   sub       in   1  0: in1+in2, 1: in1-in2                             |
// |   in1, in2  in  32  operands, captured on acceptance                   |
// |   busy      out  1  operation in progress                              |
// |   done      out  1  one-cycle pulse, result and flags valid            |
// |   result    out 32  sum / difference                                   |
// |   carry     out  1  carry out of bit 31 (sub: 1 = no borrow)           |
// |   overflow  out  1  signed two's-complement overflow                   |
// |   zero      out  1  result == 0                                        |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+

// 16-bit adder: four 4-bit lookahead groups joined by a lookahead carry unit.
module CLA_16bit_withLCU (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);
  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;

  assign w_g = in1 & in2;
  assign w_p = in1 ^ in2;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      localparam int c_lsb = 4 * gi;
      // Bit carries inside the group come straight from the group carry-in.
      assign w_c[c_lsb]   = w_gc[gi];
      assign w_c[c_lsb+1] = w_g[c_lsb] | (w_p[c_lsb] & w_gc[gi]);
      assign w_c[c_lsb+2] = w_g[c_lsb+1] | (w_p[c_lsb+1] & w_g[c_lsb])
                          | (w_p[c_lsb+1] & w_p[c_lsb] & w_gc[gi]);
      assign w_c[c_lsb+3] = w_g[c_lsb+2] | (w_p[c_lsb+2] & w_g[c_lsb+1])
                          | (w_p[c_lsb+2] & w_p[c_lsb+1] & w_g[c_lsb])
                          | (w_p[c_lsb+2] & w_p[c_lsb+1] & w_p[c_lsb] & w_gc[gi]);
      // Group generate / propagate feed the lookahead carry unit.
      assign w_gg[gi] = w_g[c_lsb+3] | (w_p[c_lsb+3] & w_g[c_lsb+2])
                      | (w_p[c_lsb+3] & w_p[c_lsb+2] & w_g[c_lsb+1])
                      | (w_p[c_lsb+3] & w_p[c_lsb+2] & w_p[c_lsb+1] & w_g[c_lsb]);
      assign w_gp[gi] = &w_p[c_lsb+3:c_lsb];
    end
  endgenerate

  // Lookahead carry unit: every group carry is flattened from c_in.
  assign w_gc[0] = c_in;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & c_in);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & c_in);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & c_in);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & c_in);

  assign sum   = w_p ^ w_c;
  assign c_out = w_gc[4];
endmodule

module cla32_seq_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry,
  output logic        overflow,
  output logic        zero
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;     // already inverted for subtraction
  logic        r_sub;
  logic        r_cin;      // carry from the low half into the high half
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;
  logic        r_carry;
  logic        r_overflow;
  logic        r_zero;

  logic        w_in_high;
  logic [15:0] w_cla_a;
  logic [15:0] w_cla_b;
  logic        w_cla_cin;
  logic [15:0] w_sum;
  logic        w_cout;

  // The shared adder sees the high half only in HIGH; otherwise the low half.
  assign w_in_high = (r_state == HIGH);
  assign w_cla_a   = w_in_high ? r_op_a[31:16] : r_op_a[15:0];
  assign w_cla_b   = w_in_high ? r_op_b[31:16] : r_op_b[15:0];
  // Subtraction is A + ~B + 1, so the "+1" enters as the low-half carry-in.
  assign w_cla_cin = w_in_high ? r_cin : r_sub;

  CLA_16bit_withLCU u_cla (
    .in1   (w_cla_a),
    .in2   (w_cla_b),
    .c_in  (w_cla_cin),
    .sum   (w_sum),
    .c_out (w_cout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_sub      <= 1'b0;
      r_cin      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op_a  <= in1;
            r_op_b  <= sub ? ~in2 : in2;
            r_sub   <= sub;
            r_busy  <= 1'b1;
            r_state <= LOW;
          end
        end
        LOW: begin
          r_result[15:0] <= w_sum;
          r_cin          <= w_cout;
          r_state        <= HIGH;
        end
        HIGH: begin
          r_result[31:16] <= w_sum;
          r_carry         <= w_cout;
          r_overflow      <= (r_op_a[31] == r_op_b[31]) && (w_sum[15] != r_op_a[31]);
          r_zero          <= ({w_sum, r_result[15:0]} == 32'd0);
          r_busy          <= 1'b0;
          r_done          <= 1'b1;
          r_state         <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign carry    = r_carry;
  assign overflow = r_overflow;
  assign zero     = r_zero;
endmodule
`default_nettype wire

// File: tb/tb_cla32_seq_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_cla32_seq_adder                                       |
// | Description : Directed self-checking bench for cla32_seq_adder.        |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_cla32_seq_adder;
  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry;
  logic        overflow;
  logic        zero;

  int n_total;
  int n_bad;

  cla32_seq_adder dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .in1      (in1),
    .in2      (in2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operation, let the next edge sample start, then scramble the
  // operand inputs so that any late sampling would corrupt the result.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    in1   = a;
    in2   = b;
    sub   = s;
    start = 1'b1;
    step();
    start = 1'b0;
    in1   = ~a;
    in2   = ~b;
    sub   = ~s;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    in1   = 32'h1234_5678;
    in2   = 32'h0000_0001;
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      step();
      n_total++;
      if ({busy, done, result, carry, overflow, zero} !== 37'd0) begin
        n_bad++;
        $display("FAIL reset_hold[%0d] got busy=%b done=%b result=%h c=%b v=%b z=%b want all 0",
                 i, busy, done, result, carry, overflow, zero);
      end
    end
    start = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_total++;
      if ({busy, done, result, carry, overflow, zero} !== 37'd0) begin
        n_bad++;
        $display("FAIL reset_release[%0d] got busy=%b done=%b result=%h c=%b v=%b z=%b want all 0",
                 i, busy, done, result, carry, overflow, zero);
      end
    end
  endtask

  // 1 + 2, with cycle-by-cycle busy/done checks.
  task automatic test_latency();
    launch(32'd1, 32'd2, 1'b0);
    n_total++;
    if ({busy, done} !== 2'b10) begin
      n_bad++;
      $display("FAIL lat_low got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    step();
    n_total++;
    if ({busy, done} !== 2'b10) begin
      n_bad++;
      $display("FAIL lat_high got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    step();
    n_total++;
    if ({busy, done, result, carry, overflow, zero} !== {2'b01, 32'd3, 3'b000}) begin
      n_bad++;
      $display("FAIL lat_done got busy=%b done=%b result=%h c=%b v=%b z=%b want busy=0 done=1 result=00000003 c=0 v=0 z=0",
               busy, done, result, carry, overflow, zero);
    end
    step();
    n_total++;
    if ({busy, done, result} !== {2'b00, 32'd3}) begin
      n_bad++;
      $display("FAIL lat_idle_hold got busy=%b done=%b result=%h want busy=0 done=0 result=00000003",
               busy, done, result);
    end
  endtask

  // Back-to-back operations; expected = {result, carry, overflow, zero}.
  task automatic test_arith();
    logic [31:0] a   [0:6];
    logic [31:0] b   [0:6];
    logic        s   [0:6];
    logic [34:0] exp [0:6];
    a[0] = 32'h0000_FFFF; b[0] = 32'h0000_0001; s[0] = 1'b0; exp[0] = {32'h0001_0000, 3'b000};
    a[1] = 32'hFFFF_FFFF; b[1] = 32'h0000_0001; s[1] = 1'b0; exp[1] = {32'h0000_0000, 3'b101};
    a[2] = 32'h7FFF_FFFF; b[2] = 32'h0000_0001; s[2] = 1'b0; exp[2] = {32'h8000_0000, 3'b010};
    a[3] = 32'h0000_0005; b[3] = 32'h0000_0007; s[3] = 1'b1; exp[3] = {32'hFFFF_FFFE, 3'b000};
    a[4] = 32'h0000_0007; b[4] = 32'h0000_0007; s[4] = 1'b1; exp[4] = {32'h0000_0000, 3'b101};
    a[5] = 32'h8000_0000; b[5] = 32'h0000_0001; s[5] = 1'b1; exp[5] = {32'h7FFF_FFFF, 3'b110};
    a[6] = 32'h1234_5678; b[6] = 32'h9ABC_DEF0; s[6] = 1'b0; exp[6] = {32'hACF1_3568, 3'b000};
    for (int i = 0; i < 7; i++) begin
      launch(a[i], b[i], s[i]);
      step();
      step();
      n_total++;
      if ({done, busy, result, carry, overflow, zero} !== {2'b10, exp[i]}) begin
        n_bad++;
        $display("FAIL arith[%0d] got done=%b busy=%b result=%h c=%b v=%b z=%b want done=1 busy=0 result=%h c=%b v=%b z=%b",
                 i, done, busy, result, carry, overflow, zero,
                 exp[i][34:3], exp[i][2], exp[i][1], exp[i][0]);
      end
      step();
    end
  endtask

  // start re-pulsed in LOW and HIGH with new operands must be ignored.
  task automatic test_ignore_start();
    launch(32'h0000_0010, 32'h0000_0020, 1'b0);
    in1   = 32'hFFFF_FFFF;
    in2   = 32'h0000_0001;
    sub   = 1'b1;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    n_total++;
    if ({done, busy, result, carry, overflow, zero} !== {2'b10, 32'h0000_0030, 3'b000}) begin
      n_bad++;
      $display("FAIL ignore_done got done=%b busy=%b result=%h c=%b v=%b z=%b want done=1 busy=0 result=00000030 c=0 v=0 z=0",
               done, busy, result, carry, overflow, zero);
    end
    step();
    step();
    n_total++;
    if ({done, busy, result} !== {2'b00, 32'h0000_0030}) begin
      n_bad++;
      $display("FAIL ignore_not_queued got done=%b busy=%b result=%h want done=0 busy=0 result=00000030",
               done, busy, result);
    end
  endtask

  // Reset in HIGH aborts with no done; next start right after release works.
  task automatic test_reset_mid();
    launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    step();
    #2;
    rst = 1'b0;
    #1;
    n_total++;
    if ({busy, done, result, carry, overflow, zero} !== 37'd0) begin
      n_bad++;
      $display("FAIL reset_mid_async got busy=%b done=%b result=%h c=%b v=%b z=%b want all 0",
               busy, done, result, carry, overflow, zero);
    end
    step();
    n_total++;
    if ({busy, done, result, carry, overflow, zero} !== 37'd0) begin
      n_bad++;
      $display("FAIL reset_mid_held got busy=%b done=%b result=%h c=%b v=%b z=%b want all 0",
               busy, done, result, carry, overflow, zero);
    end
    rst = 1'b1;
    launch(32'd3, 32'd4, 1'b0);
    step();
    step();
    n_total++;
    if ({done, busy, result, carry, overflow, zero} !== {2'b10, 32'd7, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_mid_restart got done=%b busy=%b result=%h c=%b v=%b z=%b want done=1 busy=0 result=00000007 c=0 v=0 z=0",
               done, busy, result, carry, overflow, zero);
    end
    step();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    test_reset();
    test_latency();
    test_arith();
    test_ignore_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
